// File: rtl/cu_pkg.sv
// cu_pkg: shared widths and helpers for the compute-unit writeback path
package cu_pkg;
    localparam int DEF_RF_DATASIZE = 16;
    localparam int DEF_ADDRESS_WIDTH = 4;
    localparam int DEF_NUM_UNITS = 4;
    localparam int DEF_BUF_DEPTH = 2;

    function automatic int nreg(input int aw);
        return 1 << aw;
    endfunction

    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int PTR_W = ptr_width(DEF_BUF_DEPTH);
endpackage

// File: rtl/cu_wb_fifo.sv
// cu_wb_fifo: single-channel result skid FIFO (registered head, no fall-through)
module cu_wb_fifo
    import cu_pkg::*;
#(
    parameter int DW = DEF_RF_DATASIZE,
    parameter int AW = DEF_ADDRESS_WIDTH,
    parameter int DEPTH = DEF_BUF_DEPTH
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [AW-1:0] in_addr,
    input  logic [DW-1:0] in_data,
    output logic          full,
    output logic          empty,
    output logic [AW-1:0] head_addr,
    output logic [DW-1:0] head_data
);
    localparam int PW = ptr_width(DEPTH);
    localparam int IW = PW - 1;

    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [AW+DW-1:0] mem [DEPTH];

    // extra wrap bit distinguishes full from empty when indices match
    assign empty = wr_ptr == rd_ptr;
    assign full = (wr_ptr[IW] != rd_ptr[IW]) && (wr_ptr[IW-1:0] == rd_ptr[IW-1:0]);
    assign {head_addr, head_data} = mem[rd_ptr[IW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr[IW-1:0]] <= {in_addr, in_data};
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end
endmodule

// File: rtl/cu_wb_xbar.sv
// cu_wb_xbar: round-robin writeback crossbar with bus-connect priority and busy scoreboard
// Optional bypass outputs (fwd_*) enabled by defining CU_WB_FORWARD_EN.
module cu_wb_xbar
    import cu_pkg::*;
#(
    parameter int RF_DATASIZE = DEF_RF_DATASIZE,
    parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
    parameter int NUM_UNITS = DEF_NUM_UNITS,
    parameter int BUF_DEPTH = DEF_BUF_DEPTH,
    localparam int NREG = nreg(ADDRESS_WIDTH)
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_UNITS-1:0]               res_valid,
    output logic [NUM_UNITS-1:0]               res_ready,
    input  logic [NUM_UNITS*ADDRESS_WIDTH-1:0] res_addr,
    input  logic [NUM_UNITS*RF_DATASIZE-1:0]   res_data,
    input  logic                               bc_w_en,
    input  logic [ADDRESS_WIDTH-1:0]           bc_wadd,
    input  logic [RF_DATASIZE-1:0]             bc_dt,
    input  logic                               ps_issue_en,
    input  logic [ADDRESS_WIDTH-1:0]           ps_issue_wadd,
    output logic                               rf_w_en,
    output logic [ADDRESS_WIDTH-1:0]           rf_wadd,
    output logic [RF_DATASIZE-1:0]             rf_wdt,
    output logic [NREG-1:0]                    rf_busy,
    output logic [NUM_UNITS-1:0]               wb_grant
`ifdef CU_WB_FORWARD_EN
    ,
    output logic                               fwd_valid,
    output logic [ADDRESS_WIDTH-1:0]           fwd_addr,
    output logic [RF_DATASIZE-1:0]             fwd_data
`endif
);
    localparam int UW = $clog2(NUM_UNITS);

    logic [NUM_UNITS-1:0] full, empty, push, pop, gnt_oh;
    logic [ADDRESS_WIDTH-1:0] head_addr [NUM_UNITS];
    logic [RF_DATASIZE-1:0] head_data [NUM_UNITS];
    logic [UW-1:0] ptr, gnt_idx, nxt_ptr;
    logic found, nxt_en;
    logic [ADDRESS_WIDTH-1:0] nxt_addr;
    logic [RF_DATASIZE-1:0] nxt_data;
    logic [NREG-1:0] nxt_busy;
    int cand;

    assign res_ready = ~full;
    assign push = res_valid & ~full;

    for (genvar i = 0; i < NUM_UNITS; i++) begin : g_fifo
        cu_wb_fifo #(
            .DW(RF_DATASIZE),
            .AW(ADDRESS_WIDTH),
            .DEPTH(BUF_DEPTH)
        ) u_fifo (
            .clk(clk),
            .reset(reset),
            .push(push[i]),
            .pop(pop[i]),
            .in_addr(res_addr[i*ADDRESS_WIDTH +: ADDRESS_WIDTH]),
            .in_data(res_data[i*RF_DATASIZE +: RF_DATASIZE]),
            .full(full[i]),
            .empty(empty[i]),
            .head_addr(head_addr[i]),
            .head_data(head_data[i])
        );
    end

    // first non-empty channel at or after the pointer, wrapping
    always_comb begin
        found = 1'b0;
        gnt_idx = '0;
        cand = 0;
        for (int k = 0; k < NUM_UNITS; k++) begin
            cand = int'(ptr) + k;
            cand = cand >= NUM_UNITS ? cand - NUM_UNITS : cand;
            if (!found && !empty[cand]) begin
                found = 1'b1;
                gnt_idx = UW'(cand);
            end
        end
    end

    assign gnt_oh = found ? NUM_UNITS'(1) << gnt_idx : '0;
    assign pop = bc_w_en ? '0 : gnt_oh;
    assign nxt_en = bc_w_en | found;
    assign nxt_addr = bc_w_en ? bc_wadd : head_addr[gnt_idx];
    assign nxt_data = bc_w_en ? bc_dt : head_data[gnt_idx];
    assign nxt_ptr = gnt_idx == UW'(NUM_UNITS - 1) ? '0 : gnt_idx + 1'b1;

`ifdef CU_WB_FORWARD_EN
    assign fwd_valid = nxt_en;
    assign fwd_addr = nxt_addr;
    assign fwd_data = nxt_data;
`endif

    // issue is applied after the clear so a same-cycle set wins
    always_comb begin
        nxt_busy = rf_busy;
        if (rf_w_en) nxt_busy[rf_wadd] = 1'b0;
        if (ps_issue_en) nxt_busy[ps_issue_wadd] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
            rf_w_en <= 1'b0;
            rf_wadd <= '0;
            rf_wdt <= '0;
            wb_grant <= '0;
            rf_busy <= '0;
        end else begin
            rf_w_en <= nxt_en;
            wb_grant <= pop;
            rf_busy <= nxt_busy;
            if (nxt_en) begin
                rf_wadd <= nxt_addr;
                rf_wdt <= nxt_data;
            end
            if (!bc_w_en && found) ptr <= nxt_ptr;
        end
    end
endmodule
